// File: rtl/decim_accum_pkg.sv
// Shared types for the integrate-and-dump decimator.
package decim_accum_pkg;

    localparam int CNT_W    = 20;
    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [CNT_W-1:0]           count_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_e;

endpackage

// File: rtl/decim_accum_if.sv
// Result stream from the decimator to the next stage.
interface decim_accum_if
    import decim_accum_pkg::*;
#(
    parameter int OUT_W = 16
) ();

    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [CNT_W-1:0]        out_count;

    modport master (
        output out_valid,
        output out_data,
        output out_count,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_count,
        output out_ready
    );

endinterface

// File: rtl/decim_accum_scale_sat.sv
// Window-sum scaling: optional round (DECIM_ACCUM_ROUND_EN), shift, saturate.
module decim_scale_sat #(
    parameter int ACC_W = 36,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] res
);

    // One guard bit so the rounding bias can never wrap the sum.
    localparam int EW = ACC_W + 1;

    localparam logic signed [EW-1:0] MAXV =
        {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV =
        {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EW-1:0] bias;
    logic signed [EW-1:0] biased;
    logic signed [EW-1:0] shifted;

`ifdef DECIM_ACCUM_ROUND_EN
    if (SHIFT > 0) begin : g_rnd
        assign bias = EW'(1) << (SHIFT - 1);
    end else begin : g_nrnd
        assign bias = '0;
    end
`else
    assign bias = '0;
`endif

    always_comb begin
        biased  = {sum[ACC_W-1], sum} + bias;
        shifted = biased >>> SHIFT;
        if (shifted > MAXV) begin
            res = MAXV[OUT_W-1:0];
        end else if (shifted < MINV) begin
            res = MINV[OUT_W-1:0];
        end else begin
            res = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/decim_accum.sv
// Integrate-and-dump decimator closed by clken; rounding via DECIM_ACCUM_ROUND_EN.
module decim_accum
    import decim_accum_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 36,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    decim_accum_if.master     out_if,
    output logic              overrun,
    input  logic              clear_overrun
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] smp;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic signed [OUT_W-1:0] res;
    logic signed [OUT_W-1:0] data_q;
    logic [CNT_W-1:0]        count_q;
    ostate_e                 state;

    assign smp = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign sum = in_valid ? acc + smp : acc;

    // Count saturates rather than wrapping in over-long windows.
    assign cnt_nxt = (in_valid && cnt != '1) ? cnt + CNT_W'(1) : cnt;

    decim_scale_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_scale (
        .sum (sum),
        .res (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clken) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= sum;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else if (clken) begin
            state   <= FULL;
            data_q  <= res;
            count_q <= cnt_nxt;
        end else if (state == FULL && out_if.out_ready) begin
            state   <= EMPTY;
        end
    end

    // A dump into an unaccepted result beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (clken && state == FULL && !out_if.out_ready) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign out_if.out_valid = (state == FULL);
    assign out_if.out_data  = data_q;
    assign out_if.out_count = count_q;

endmodule
